// File: rtl/mem_access_unit.sv
// MEM-stage data bus initiator: sub-word loads/stores over a word-wide bus.
// Sub-word stores are done as read-modify-write; faults are reported on done.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic        i_is_store,
  input  logic [1:0]  i_size,
  input  logic        i_sign_ext,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata_out,
  output logic [1:0]  o_fault,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_accessable
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [1:0] F_OK  = 2'b00;
  localparam logic [1:0] F_MIS = 2'b01;
  localparam logic [1:0] F_ACC = 2'b10;

  state_t      r_state;
  state_t      w_next;

  logic        r_is_store;
  logic [1:0]  r_size;
  logic        r_sign_ext;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merged;
  logic [31:0] r_rdata_out;
  logic [1:0]  r_fault;

  logic        w_misaligned;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_is_byte;
  logic        w_is_half;
  logic [31:0] w_load_val;
  logic [31:0] w_merged;

  // Alignment is judged on the live request, before anything is latched
  always_comb begin
    w_misaligned = 1'b0;
    unique case (i_size)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = i_addr[0];
      default: w_misaligned = |i_addr[1:0];
    endcase
  end

  assign w_is_byte = (r_size == 2'b00);
  assign w_is_half = (r_size == 2'b01);

  always_comb begin
    w_byte = 8'h00;
    unique case (r_addr[1:0])
      2'd0: w_byte = i_mem_rdata[7:0];
      2'd1: w_byte = i_mem_rdata[15:8];
      2'd2: w_byte = i_mem_rdata[23:16];
      2'd3: w_byte = i_mem_rdata[31:24];
    endcase
  end

  assign w_half = r_addr[1] ? i_mem_rdata[31:16]
                            : i_mem_rdata[15:0];

  always_comb begin
    w_load_val = i_mem_rdata;
    unique case (1'b1)
      w_is_byte:
        w_load_val = {{24{r_sign_ext & w_byte[7]}}, w_byte};
      w_is_half:
        w_load_val = {{16{r_sign_ext & w_half[15]}}, w_half};
      default:
        w_load_val = i_mem_rdata;
    endcase
  end

  // Old word with only the addressed lane overwritten
  always_comb begin
    w_merged = i_mem_rdata;
    unique case (1'b1)
      w_is_byte:
        w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      w_is_half:
        w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default:
        w_merged = r_wdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_next = w_misaligned ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (!i_mem_accessable) begin
          w_next = S_DONE;
        end else if (r_is_store) begin
          w_next = S_WRITE;
        end else begin
          w_next = S_DONE;
        end
      end
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_is_store  <= 1'b0;
      r_size      <= 2'b00;
      r_sign_ext  <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_merged    <= 32'h0;
      r_rdata_out <= 32'h0;
      r_fault     <= F_OK;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_is_store <= i_is_store;
            r_size     <= i_size;
            r_sign_ext <= i_sign_ext;
            r_addr     <= i_addr;
            r_wdata    <= i_wdata;
            if (w_misaligned) begin
              r_fault <= F_MIS;
            end
          end
        end
        S_READ: begin
          if (!i_mem_accessable) begin
            r_fault <= F_ACC;
          end else if (r_is_store) begin
            r_merged <= w_merged;
          end else begin
            r_rdata_out <= w_load_val;
            r_fault     <= F_OK;
          end
        end
        S_WRITE: r_fault <= F_OK;
        S_DONE:  ;
      endcase
    end
  end

  // Strobes come straight from the state so reset kills them at once
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_mem_rd    = (r_state == S_READ);
  assign o_mem_wr    = (r_state == S_WRITE);
  assign o_mem_addr  = {r_addr[31:2], 2'b00};
  assign o_mem_wdata = r_merged;
  assign o_rdata_out = r_rdata_out;
  assign o_fault     = r_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small data memory
// and a spec-level access model checked every cycle.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, mem_rd, mem_wr;
  logic [31:0] rdata_out, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  fault;
  logic        mem_accessable;
  logic        tb_acc = 1'b1;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_req            (req),
    .i_is_store       (is_store),
    .i_size           (size),
    .i_sign_ext       (sign_ext),
    .i_addr           (addr),
    .i_wdata          (wdata),
    .o_busy           (busy),
    .o_done           (done),
    .o_rdata_out      (rdata_out),
    .o_fault          (fault),
    .o_mem_rd         (mem_rd),
    .o_mem_wr         (mem_wr),
    .o_mem_addr       (mem_addr),
    .o_mem_wdata      (mem_wdata),
    .i_mem_rdata      (mem_rdata),
    .i_mem_accessable (mem_accessable)
  );

  logic [31:0] mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = 4'h0;
  logic [31:0] pl_val = 32'h0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  assign mem_rdata      = mem[mem_addr[5:2]];
  assign mem_accessable = tb_acc;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) rd_cnt <= rd_cnt + 1;
    if (pl_en) begin
      mem[pl_idx] <= pl_val;
    end else if (mem_wr) begin
      wr_cnt <= wr_cnt + 1;
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Expectation for the access in flight
  bit          mon_en = 1'b0;
  bit          pending = 1'b0;
  int          exp_start = 0;
  int          exp_done = 0;
  logic [1:0]  exp_fault = 2'b00;
  logic [31:0] exp_rd = 32'h0;
  logic [31:0] exp_maddr = 32'h0;
  logic [31:0] model_rdata = 32'h0;

  function automatic void model(
    input logic st, input logic [1:0] sz, input logic sx,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] memw, input logic acc,
    output int lat, output logic [1:0] flt,
    output logic [31:0] rd, output logic [31:0] nw);
    int n, sh;
    logic [31:0] mask;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    sh = 8 * int'(a[1:0]);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    nw = memw;
    rd = 32'h0;
    if ((int'(a[1:0]) % n) != 0) begin
      lat = 1; flt = 2'b01;
    end else if (!acc) begin
      lat = 2; flt = 2'b10;
    end else begin
      flt = 2'b00;
      lat = st ? 3 : 2;
      if (st) begin
        nw = (memw & ~(mask << sh)) | ((wd & mask) << sh);
      end else begin
        rd = (memw >> sh) & mask;
        if (sx && n < 4 && rd[8 * n - 1]) rd = rd | ~mask;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      logic exp_busy;
      exp_busy = pending && cyc >= exp_start && cyc <= exp_done;
      chk("strobe_excl", {31'b0, mem_rd & mem_wr}, 32'h0);
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
      if (mem_rd || mem_wr) chk("mem_addr", mem_addr, exp_maddr);
      if (pending && cyc == exp_done) begin
        chk("done", {31'b0, done}, 32'h1);
        chk("fault", {30'b0, fault}, {30'b0, exp_fault});
        chk("rdata_out", rdata_out, exp_rd);
        model_rdata = exp_rd;
        pending = 1'b0;
      end else begin
        chk("no_done", {31'b0, done}, 32'h0);
        chk("rdata_hold", rdata_out, model_rdata);
      end
    end
  end

  task automatic preload(input logic [3:0] idx, input logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 12 && pending; i++) @(posedge clk);
    #1;
    if (pending) begin
      n_chk++;
      $display("FAIL timeout: done never seen, wanted at cycle %0d",
               exp_done);
      pending = 1'b0;
    end
  endtask

  task automatic expect_acc(input int e, input int lat,
                            input logic [1:0] flt, input logic st,
                            input logic [31:0] rd, input logic [31:0] a);
    exp_start = e;
    exp_done  = e + lat - 1;
    exp_fault = flt;
    exp_rd    = (!st && flt == 2'b00) ? rd : model_rdata;
    exp_maddr = {a[31:2], 2'b00};
    pending   = 1'b1;
  endtask

  task automatic run(input logic st, input logic [1:0] sz,
                     input logic sx, input logic [31:0] a,
                     input logic [31:0] wd, input logic acc,
                     input logic [31:0] memw);
    int lat, e, r0, w0;
    logic [1:0] flt;
    logic [31:0] rd, nw;
    logic [3:0] idx;
    logic wrote;
    idx = a[5:2];
    preload(idx, memw);
    model(st, sz, sx, a, wd, memw, acc, lat, flt, rd, nw);
    wrote = st && flt == 2'b00;
    @(negedge clk);
    is_store = st; size = sz; sign_ext = sx;
    addr = a; wdata = wd; tb_acc = acc; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    e = cyc; r0 = rd_cnt; w0 = wr_cnt;
    expect_acc(e, lat, flt, st, rd, a);
    wait_done();
    chk("rd_count", rd_cnt - r0, (flt == 2'b01) ? 1 - 1 : 1);
    chk("wr_count", wr_cnt - w0, wrote ? 1 : 0);
    chk("mem_word", mem[idx], wrote ? nw : memw);
  endtask

  initial begin
    int e, w0, lat;
    logic [1:0] flt;
    logic [31:0] rd, nw1, nw2;

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_fault", {30'b0, fault}, 32'h0);
    chk("rst_rdata", rdata_out, 32'h0);
    chk("rst_mem_rd", {31'b0, mem_rd}, 32'h0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);
    reset_n = 1'b1;
    mon_en = 1'b1;

    // Loads
    run(0, 2'b10, 1, 32'h1001_0004, 32'h0, 1, 32'h8899_AABC);
    chk("lw_lit", rdata_out, 32'h8899_AABC);
    run(0, 2'b00, 1, 32'h1001_0007, 32'h0, 1, 32'h8011_2233);
    chk("lb_lit", rdata_out, 32'hFFFF_FF80);
    run(0, 2'b00, 0, 32'h1001_0007, 32'h0, 1, 32'h8011_2233);
    chk("lbu_lit", rdata_out, 32'h0000_0080);
    run(0, 2'b01, 1, 32'h1001_0006, 32'h0, 1, 32'h8011_2233);
    chk("lh_lit", rdata_out, 32'hFFFF_8011);
    run(0, 2'b01, 0, 32'h1001_0004, 32'h0, 1, 32'h8011_F00D);
    chk("lhu_lit", rdata_out, 32'h0000_F00D);
    run(0, 2'b01, 1, 32'h1001_000C, 32'h0, 1, 32'h0000_F00D);
    chk("lh0_lit", rdata_out, 32'hFFFF_F00D);
    run(0, 2'b11, 1, 32'h1001_0008, 32'h0, 1, 32'hCAFE_F00D);
    chk("lw11_lit", rdata_out, 32'hCAFE_F00D);
    run(0, 2'b00, 1, 32'h1001_000A, 32'h0, 1, 32'h12F4_56A5);
    chk("lb2_lit", rdata_out, 32'hFFFF_FFF4);
    run(0, 2'b00, 1, 32'h1001_0008, 32'h0, 1, 32'h12F4_5625);
    chk("lb0_lit", rdata_out, 32'h0000_0025);

    // Stores
    run(1, 2'b00, 0, 32'h7FFF_F001, 32'h0000_00EE, 1, 32'h1122_3344);
    chk("sb_lit", mem[0], 32'h1122_EE44);
    run(1, 2'b01, 0, 32'h2000_0006, 32'h7777_ABCD, 1, 32'h1122_3344);
    chk("sh_lit", mem[1], 32'hABCD_3344);
    run(1, 2'b10, 0, 32'h2000_000C, 32'hDEAD_BEEF, 1, 32'h1122_3344);
    chk("sw_lit", mem[3], 32'hDEAD_BEEF);
    run(1, 2'b00, 0, 32'h2000_0013, 32'h1234_565A, 1, 32'h0000_0000);
    chk("sb3_lit", mem[4], 32'h5A00_0000);

    // Faults
    run(0, 2'b10, 0, 32'h1001_0002, 32'h0, 1, 32'h5555_5555);
    chk("mis_lit", {30'b0, fault}, 32'h1);
    run(1, 2'b01, 0, 32'h1001_0005, 32'h0000_BEEF, 1, 32'h6666_6666);
    run(1, 2'b10, 0, 32'h0000_0000, 32'h1234_5678, 0, 32'h7777_7777);
    chk("acc_lit", {30'b0, fault}, 32'h2);
    run(0, 2'b10, 0, 32'h0000_0000, 32'h0, 0, 32'h7777_7777);
    tb_acc = 1'b1;

    // Back-to-back stores with req held high
    preload(4'd2, 32'h0102_0304);
    preload(4'd3, 32'h0506_0708);
    @(negedge clk);
    is_store = 1; size = 2'b00; sign_ext = 0;
    addr = 32'h0000_0008; wdata = 32'h0000_00AA; req = 1'b1;
    @(posedge clk); #1;
    e = cyc; w0 = wr_cnt;
    model(1, 2'b00, 0, 32'h0000_0008, 32'h0000_00AA,
          32'h0102_0304, 1, lat, flt, rd, nw1);
    expect_acc(e, lat, flt, 1, rd, 32'h0000_0008);
    addr = 32'h0000_000D; wdata = 32'h0000_00BB;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_first_done", {31'b0, pending}, 32'h0);
    model(1, 2'b00, 0, 32'h0000_000D, 32'h0000_00BB,
          32'h0506_0708, 1, lat, flt, rd, nw2);
    expect_acc(e + 4, lat, flt, 1, rd, 32'h0000_000D);
    @(posedge clk); #1;
    req = 1'b0;
    wait_done();
    chk("b2b_word0", mem[2], nw1);
    chk("b2b_word1", mem[3], nw2);
    chk("b2b_lit", mem[3], 32'h0506_BB08);
    chk("b2b_wr_count", wr_cnt - w0, 32'd2);

    // Reset during WRITE
    preload(4'd5, 32'hA5A5_A5A5);
    @(negedge clk);
    is_store = 1; size = 2'b00; addr = 32'h0000_0014;
    wdata = 32'h0000_003C; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    mon_en = 1'b0;
    for (int i = 0; i < 6 && !mem_wr; i++) @(negedge clk);
    chk("abort_saw_wr", {31'b0, mem_wr}, 32'h1);
    reset_n = 1'b0;
    w0 = wr_cnt;
    #1;
    chk("abort_mem_wr", {31'b0, mem_wr}, 32'h0);
    chk("abort_mem_rd", {31'b0, mem_rd}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_fault", {30'b0, fault}, 32'h0);
    chk("abort_rdata", rdata_out, 32'h0);
    chk("abort_maddr", mem_addr, 32'h0);
    chk("abort_mwdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    chk("abort_word", mem[5], 32'hA5A5_A5A5);
    chk("abort_wr_count", wr_cnt - w0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_rdata = 32'h0;
    pending = 1'b0;
    mon_en = 1'b1;
    run(0, 2'b10, 0, 32'h0000_0014, 32'h0, 1, 32'hA5A5_A5A5);
    chk("post_rst_lit", rdata_out, 32'hA5A5_A5A5);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the data-memory bus: sits in the CPU MEM stage and converts load/store requests of byte, halfword or word size into word-aligned `rd`/`wr` cycles on the data-memory interface. Sub-word stores are done as read-modify-write. Accesses the memory reports as not accessible, and misaligned accesses, are turned into a fault status for the exception logic. The memory side has combinational reads (data and `accessable` valid in the same cycle as `mem_rd`) and writes on posedge `clk`.

## Interface
- No parameters.
- `clk`  in  1  clock; all state changes on posedge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req`  in  1  access request; sampled only in IDLE.
- `is_store`  in  1  1 = store, 0 = load.
- `size`  in  2  access size: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `sign_ext`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; the byte or half is taken from the low bits.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rdata_out`  out  32  extended load result; valid while `done` is high and held until the next `done`.
- `fault`  out  2  valid with `done`: 00 = ok, 01 = misaligned, 10 = inaccessible.
- `mem_rd`  out  1  read strobe to data memory.
- `mem_wr`  out  1  write strobe to data memory.
- `mem_addr`  out  32  word address: {latched addr[31:2], 2'b00}.
- `mem_wdata`  out  32  merged write word.
- `mem_rdata`  in  32  read data (combinational).
- `mem_accessable`  in  1  1 = the address is valid in the current cycle.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - When `req`=1, latch `is_store`, `size`, `sign_ext`, `addr` and `wdata`.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. A misaligned request goes to DONE with fault=01 and makes no memory access.
  - Any other request goes to READ.
- READ:
  - `mem_rd`=1 and `mem_addr` is driven for exactly one cycle.
  - At the closing edge, sample `mem_rdata` and `mem_accessable`.
  - If `mem_accessable`=0: go to DONE with fault=10. No write is issued and `rdata_out` is left unchanged.
  - If the access is a load: extract the lane, extend it, register it into `rdata_out`, then go to DONE.
  - If the access is a store: register merged = rdata with the target lane replaced by the wdata low bits, then go to WRITE.
  - Word stores also pass through READ, which serves as the access probe; all 32 bits are replaced.
- Lane selection is little-endian:
  - byte k = addr[1:0] occupies bits [8k+7:8k];
  - half h = addr[1] occupies bits [16h+15:16h].
- Extension: with `sign_ext`=1, the top bit of the lane is replicated; otherwise the upper bits are zero-filled. Words pass through unchanged.
- WRITE: `mem_wr`=1 with `mem_wdata`=merged and `mem_addr` held for exactly one cycle; memory commits at the closing edge. Then go to DONE with fault=00.
- DONE: `done`=1 for one cycle, then IDLE.
- `req` is ignored outside IDLE. A new request can be accepted on the edge that leaves DONE+1, i.e. while in IDLE.
- `mem_rd` and `mem_wr` are decoded from the registered state, never both high, and zero in IDLE and DONE.

## Timing
- Reset (asynchronous) forces, immediately:
  - state=IDLE;
  - `busy`=0, `done`=0, `fault`=00, `rdata_out`=0;
  - `mem_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset asserted during READ or WRITE drops the strobe in the same cycle. A WRITE aborted before its closing edge must not commit.
- Latency is counted from the accepting edge E (req=1 in IDLE):
  - load: `done` is high in cycle E+2;
  - store: `done` is high in cycle E+3;
  - misaligned: `done` is high in cycle E+1.
- `busy` rises the cycle after E and falls together with `done` leaving DONE.
- `mem_addr` is stable across READ and WRITE of one access.

## Test plan
- Load word, sign_ext=x, addr 0x10010004, memory returns 0x8899AABC, acc=1 -> `mem_rd` pulse with mem_addr=0x10010004, then `done` at E+2, rdata_out=0x8899AABC, fault=00.
- Signed byte load, addr 0x10010007, memory word 0x80112233 -> rdata_out=0xFFFFFF80. The same access with sign_ext=0 -> rdata_out=0x00000080. The signed half load at addr 0x10010006 -> 0xFFFF8011.
- Store byte 0x000000EE to 0x7FFFF001, memory word 0x11223344 -> READ then WRITE with mem_wdata=0x1122EE44. `done` at E+3; reading the word back returns 0x1122EE44.
- Load word at 0x10010002 -> fault=01 at E+1, with no `mem_rd` or `mem_wr` ever asserted. A store to address 0x00000000 with acc=0 -> fault=10 at E+2, with no `mem_wr`.
- Back-to-back: req held high across two stores -> the second is accepted only after DONE. Asserting reset_n=0 mid-WRITE -> mem_wr=0 immediately, the target word is unchanged, and all outputs are at their reset values.
